// File: rtl/watch_pkg.sv
// Shared encodings for the watch controller: display modes, setting-field selector
// and the selector stepping helpers used by the left/right buttons.
package watch_pkg;

    typedef enum logic [1:0] {
        MODE_RUN = 2'd0,
        MODE_SET = 2'd1,
        MODE_SW  = 2'd2
    } mode_e;

    typedef enum logic [1:0] {
        SEL_0 = 2'd0,
        SEL_1 = 2'd1,
        SEL_2 = 2'd2
    } sel_e;

    function automatic sel_e sel_step_left(input sel_e s);
        case (s)
            SEL_0:   return SEL_1;
            SEL_1:   return SEL_2;
            default: return SEL_0;
        endcase
    endfunction

    function automatic sel_e sel_step_right(input sel_e s);
        case (s)
            SEL_0:   return SEL_2;
            SEL_2:   return SEL_1;
            default: return SEL_0;
        endcase
    endfunction

endpackage

// File: rtl/btn_repeat.sv
// Button edge detector with hold-to-repeat: a first repeat pulse after REPEAT_DELAY
// ticks of solo holding, then one every REPEAT_RATE ticks.
module btn_repeat #(
    parameter int REPEAT_DELAY = 500,
    parameter int REPEAT_RATE  = 100
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic btn,
    input  logic other_lvl,
    input  logic enable,
    output logic lvl,
    output logic press,
    output logic fire
);

    localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] DELAY_C = CW'(REPEAT_DELAY);
    localparam logic [CW-1:0] RATE_C  = CW'(REPEAT_RATE);

    logic          lvl_q, lvl_d;
    logic          prev_q, prev_d;
    logic          rep_q, rep_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] cnt_inc;
    logic [CW-1:0] target;
    logic          run;

    // Counting only happens while this button is the only one of the pair held;
    // rep_q switches the target from the initial delay to the repeat rate.
    always_comb begin
        lvl_d   = btn;
        prev_d  = lvl_q;
        run     = enable & lvl_q & ~other_lvl;
        target  = rep_q ? RATE_C : DELAY_C;
        cnt_inc = cnt_q + CW'(1);
        cnt_d   = cnt_q;
        rep_d   = rep_q;
        fire    = 1'b0;
        if (!run) begin
            cnt_d = '0;
            rep_d = 1'b0;
        end else if (tick) begin
            if (cnt_inc == target) begin
                fire  = 1'b1;
                cnt_d = '0;
                rep_d = 1'b1;
            end else begin
                cnt_d = cnt_inc;
            end
        end
    end

    assign lvl   = lvl_q;
    assign press = lvl_q & ~prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lvl_q  <= 1'b0;
            prev_q <= 1'b0;
            rep_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            lvl_q  <= lvl_d;
            prev_q <= prev_d;
            rep_q  <= rep_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/watch_mode_ctrl.sv
// Watch user-interface controller: cycles RUN/SET/SW modes, selects and adjusts
// time fields in SET with auto-repeat, idle timeout and blink, and drives the stopwatch.
module watch_mode_ctrl
    import watch_pkg::*;
#(
    parameter int REPEAT_DELAY = 500,
    parameter int REPEAT_RATE  = 100,
    parameter int SET_TIMEOUT  = 10000,
    parameter int BLINK_HALF   = 250
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       btn_mode,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_up,
    input  logic       btn_down,
    output logic [1:0] mode,
    output logic [1:0] sel_pos,
    output logic       o_inc,
    output logic       o_dec,
    output logic       sw_run,
    output logic       sw_clear,
    output logic       blink
);

    localparam int TW = $clog2(SET_TIMEOUT + 1);
    localparam int BW = $clog2(BLINK_HALF + 1);
    localparam logic [TW-1:0] TO_LIMIT    = TW'(SET_TIMEOUT);
    localparam logic [BW-1:0] BLINK_LIMIT = BW'(BLINK_HALF);

    mode_e         mode_q, mode_d;
    sel_e          sel_q, sel_d;
    logic [2:0]    lvl_q, lvl_d;
    logic [2:0]    prev_q, prev_d;
    logic [TW-1:0] to_q, to_d;
    logic [BW-1:0] bc_q, bc_d;
    logic          inc_q, inc_d;
    logic          dec_q, dec_d;
    logic          run_q, run_d;
    logic          clr_q, clr_d;
    logic          blink_q, blink_d;

    logic up_lvl, dn_lvl, up_press, dn_press, up_fire, dn_fire;
    logic mode_press, left_raw, right_raw;
    logic left_p, right_p, up_p, dn_p, any_press;
    logic in_set, in_sw, timeout, entering;

    assign in_set = (mode_q == MODE_SET);
    assign in_sw  = (mode_q == MODE_SW);

    btn_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)) u_up (
        .clk(clk), .rst(rst), .tick(tick), .btn(btn_up), .other_lvl(dn_lvl),
        .enable(in_set), .lvl(up_lvl), .press(up_press), .fire(up_fire)
    );

    btn_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)) u_dn (
        .clk(clk), .rst(rst), .tick(tick), .btn(btn_down), .other_lvl(up_lvl),
        .enable(in_set), .lvl(dn_lvl), .press(dn_press), .fire(dn_fire)
    );

    // Bit order of the local edge detectors: {right, left, mode}.
    always_comb begin
        lvl_d  = {btn_right, btn_left, btn_mode};
        prev_d = lvl_q;
    end

    assign mode_press = lvl_q[0] & ~prev_q[0];
    assign left_raw   = lvl_q[1] & ~prev_q[1];
    assign right_raw  = lvl_q[2] & ~prev_q[2];
    assign left_p     = left_raw & ~mode_press;
    assign right_p    = right_raw & ~mode_press;
    assign up_p       = up_press & ~mode_press;
    assign dn_p       = dn_press & ~mode_press;
    assign any_press  = mode_press | left_raw | right_raw | up_press | dn_press;

    always_comb begin
        to_d    = to_q;
        timeout = 1'b0;
        if (!in_set || any_press) begin
            to_d = '0;
        end else if (tick) begin
            if (to_q + TW'(1) == TO_LIMIT) begin
                timeout = 1'b1;
                to_d    = '0;
            end else begin
                to_d = to_q + TW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) mode_q <= MODE_RUN;
        else     mode_q <= mode_d;
    end

    always_comb begin
        mode_d = mode_q;
        if (mode_press) begin
            case (mode_q)
                MODE_RUN: mode_d = MODE_SET;
                MODE_SET: mode_d = MODE_SW;
                default:  mode_d = MODE_RUN;
            endcase
        end else if (timeout) begin
            mode_d = MODE_RUN;
        end
    end

    // Registered outputs; a selector change restarts the blink phase so the new field shows at once.
    always_comb begin
        entering = (mode_d == MODE_SET) && (mode_q != MODE_SET);
        inc_d    = in_set & ~mode_press & ((up_press & ~dn_press) | up_fire);
        dec_d    = in_set & ~mode_press & ((dn_press & ~up_press) | dn_fire);
        run_d    = run_q ^ (in_sw & up_p);
        clr_d    = in_sw & dn_p & ~run_q;
        sel_d    = sel_q;
        blink_d  = blink_q;
        bc_d     = bc_q;
        if (entering)                sel_d = SEL_0;
        else if (in_set && left_p)   sel_d = sel_step_left(sel_q);
        else if (in_set && right_p)  sel_d = sel_step_right(sel_q);
        if (mode_d != MODE_SET) begin
            blink_d = 1'b0;
            bc_d    = '0;
        end else if (entering || (sel_d != sel_q)) begin
            blink_d = 1'b1;
            bc_d    = '0;
        end else if (tick) begin
            if (bc_q + BW'(1) == BLINK_LIMIT) begin
                blink_d = ~blink_q;
                bc_d    = '0;
            end else begin
                bc_d = bc_q + BW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lvl_q   <= '0;
            prev_q  <= '0;
            to_q    <= '0;
            bc_q    <= '0;
            sel_q   <= SEL_0;
            inc_q   <= 1'b0;
            dec_q   <= 1'b0;
            run_q   <= 1'b0;
            clr_q   <= 1'b0;
            blink_q <= 1'b0;
        end else begin
            lvl_q   <= lvl_d;
            prev_q  <= prev_d;
            to_q    <= to_d;
            bc_q    <= bc_d;
            sel_q   <= sel_d;
            inc_q   <= inc_d;
            dec_q   <= dec_d;
            run_q   <= run_d;
            clr_q   <= clr_d;
            blink_q <= blink_d;
        end
    end

    assign mode     = mode_q;
    assign sel_pos  = sel_q;
    assign o_inc    = inc_q;
    assign o_dec    = dec_q;
    assign sw_run   = run_q;
    assign sw_clear = clr_q;
    assign blink    = blink_q;

endmodule

// File: doc/watch_mode_ctrl.md
WATCH_MODE_CTRL -- requirements
Module: watch_mode_ctrl

Interface
REQ-001 SHALL have parameter REPEAT_DELAY, 500, tick count a held up/down button must stay held before the first auto-repeat pulse.
REQ-002 SHALL have parameter REPEAT_RATE, 100, tick count between later auto-repeat pulses.
REQ-003 SHALL have parameter SET_TIMEOUT, 10000, idle tick count in SET before an automatic return to RUN.
REQ-004 SHALL have parameter BLINK_HALF, 250, tick count per blink half-period.
REQ-005 SHALL have port clk  in  1  clock; reset rst, asynchronous, active-high.
REQ-006 SHALL have port rst  in  1  asynchronous active-high reset.
REQ-007 SHALL have port tick  in  1  one-cycle 1 kHz time-base enable.
REQ-008 SHALL have ports btn_mode, btn_left, btn_right, btn_up, btn_down  in  1 each  debounced button levels, synchronous to clk.
REQ-009 SHALL have port mode  out  2  0=RUN, 1=SET, 2=SW (stopwatch).
REQ-010 SHALL have port sel_pos  out  2  field selected for setting: 0, 1, 2.
REQ-011 SHALL have ports o_inc, o_dec  out  1 each  one-cycle adjust pulses to the time datapath.
REQ-012 SHALL have ports sw_run (level) and sw_clear (one-cycle pulse)  out  1 each  stopwatch controls.
REQ-013 SHALL have port blink  out  1  display blink enable for the selected field.

Function
REQ-014 SHALL define a press as level=1 with the previous-cycle level=0; every output SHALL be registered, so a press sampled at edge N SHALL drive its response after edge N+1 (1-cycle latency).
REQ-015 SHALL advance mode RUN->SET->SW->RUN on each btn_mode press; a btn_mode press SHALL suppress all other presses in the same cycle.
REQ-016 SHALL load sel_pos=0 on entry to SET; in SET, a left press SHALL step sel_pos 0->1->2->0 and a right press SHALL step it 0->2->1->0; when both press in the same cycle, left SHALL win; sel_pos SHALL hold outside SET.
REQ-017 SHALL, in SET only, pulse o_inc on an up press and o_dec on a down press; simultaneous up and down presses SHALL produce no pulse.
REQ-018 SHALL provide auto-repeat: while up (or down) is held alone in SET, count ticks; at count REPEAT_DELAY issue a pulse, then one pulse every REPEAT_RATE ticks; release, leaving SET, or a press of the other button SHALL clear the count.
REQ-019 SHALL count ticks in SET, clear the count on any button press, and go to RUN when the count reaches SET_TIMEOUT.
REQ-020 SHALL, in SW, toggle sw_run on an up press; a down press with sw_run=0 SHALL pulse sw_clear; a down press with sw_run=1 SHALL be ignored.
REQ-021 SHALL retain sw_run across mode changes (the stopwatch runs in the background).
REQ-022 SHALL, in SET, drive blink=1 on entry and on each sel_pos change, and toggle it every BLINK_HALF ticks; blink SHALL be 0 outside SET.
REQ-023 SHALL keep o_inc, o_dec and sw_clear at 0 except during their single pulse cycles.

Reset
REQ-024 SHALL, on rst, set mode=RUN, sel_pos=0, o_inc=o_dec=sw_run=sw_clear=blink=0, all counters=0, and all previous-level registers=0, independent of clk.
REQ-025 SHALL, after rst deasserts, treat a button already held as a fresh press on the first cycle.

Structure
REQ-026 SHALL take the mode encodings (RUN/SET/SW) and sel_pos encodings from shared package watch_pkg.
REQ-027 SHALL use one sub-module, btn_repeat (edge detect plus auto-repeat counter), instantiated for up and for down.

Verification
REQ-028 SHALL cover: three btn_mode presses from reset -> mode 1, 2, 0; mode=1 is followed by sel_pos=0 and blink=1.
REQ-029 SHALL cover: in SET, left x3 -> sel_pos 1, 2, 0; right x1 -> 2; left and right together from 0 -> 1.
REQ-030 SHALL cover: in SET, hold up for 800 ticks (defaults) -> pulses at ticks 500, 600, 700 and 800, plus one at the press, i.e. 5 o_inc in total.
REQ-031 SHALL cover: in SET with no input for 10000 ticks -> mode=0; a press at tick 9999 -> mode stays 1.
REQ-032 SHALL cover: in SW, up -> sw_run=1; down -> no sw_clear; up -> sw_run=0; down -> one sw_clear pulse; mode to RUN and back with sw_run=1 -> sw_run held.
REQ-033 SHALL cover: rst asserted mid-auto-repeat in SET -> all outputs 0 and mode=0 immediately, with no pulse in the following cycle.
